alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
// - Issue side of the ALU operation interface: decodes RV32I instruction fields into the 4-bit ALU op code
//   and the two ALU operands, then registers them toward the ALU through a 2-entry valid/ready skid buffer.
// - Sits between register-file read and ALU in the pipelined core; isolates decode timing from the ALU path.
// PARAMETERS
// - XLEN  32  operand/PC width (only 32 supported)
// PORTS
// - clk                input   1     clock, all state on rising edge
// - rst                input   1     synchronous, active-high reset
// - flush              input   1     synchronous pipeline flush, drops all held entries
// - in_valid           input   1     upstream has instruction + operands
// - in_ready           output  1     stage can accept this cycle
// - in_instr           input   32    raw instruction word
// - in_pc              input   32    PC of instruction
// - in_rs1_data        input   32    rs1 register value
// - in_rs2_data        input   32    rs2 register value
// - out_valid          output  1     issued entry present
// - out_ready          input   1     ALU/EX consumes entry this cycle
// - out_alu_operation  output  4     ALU op code
// - out_data1          output  32    ALU operand 1
// - out_data2          output  32    ALU operand 2
// - out_rd             output  5     destination register (instr[11:7])
// - out_reg_write      output  1     writeback enable
// - out_branch         output  1     entry is a conditional branch
// - out_funct3         output  3     instr[14:12], passed through for branch sense
// - out_illegal        output  1     unsupported/malformed encoding
// BEHAVIOUR
// - Op codes: AND=0000 OR=0001 ADD=0010 XOR=0011 SUB=0110 SLL=1001 SLT=1010 SLTU=1011 SRL=1100 SRA=1101.
// - OP 0110011: data1=rs1, data2=rs2; funct3 000: ADD (f7=0000000) / SUB (f7=0100000); 101: SRL/SRA likewise;
//   001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND require f7=0000000; reg_write=1.
// - OP-IMM 0010011: data1=rs1, data2=sign-extended I-imm; 000 ADD (never SUB); 001 SLL needs f7=0000000;
//   101 SRL (f7=0000000) / SRA (f7=0100000); shifts: data2={27'b0,instr[24:20]}; reg_write=1.
// - LUI 0110111: ADD, data1=0, data2={instr[31:12],12'b0}; AUIPC 0010111: ADD, data1=pc, same data2; reg_write=1.
// - BRANCH 1100011: data1=rs1, data2=rs2, branch=1, reg_write=0; BEQ/BNE->SUB, BLT/BGE->SLT, BLTU/BGEU->SLTU;
//   funct3 010/011 illegal.
// - Any other opcode/funct combo (incl. f7=0000001 M-ext): illegal=1, op=0000, data1=data2=0, reg_write=0, branch=0.
// - rd=0 still issued with reg_write=1; suppression is writeback's job.
// - Handshake: transfer when valid&&ready on either side. Latency 1 cycle input accept -> out_valid.
//   Throughput 1/cycle while out_ready=1. All out_* stable while out_valid && !out_ready.
// - Skid: entries MAIN (drives out_*) and SKID. in_ready = !skid_valid && !rst && !flush (skid_valid registered).
//   Accept with MAIN empty or consumed -> MAIN; accept with MAIN held -> SKID; MAIN consumed with SKID full
//   -> SKID moves to MAIN same edge, in_ready returns next cycle. Order preserved, no entry dropped/duplicated.
// - Simultaneous accept + consume, MAIN full, SKID empty: new entry replaces MAIN, out_valid stays 1.
// - flush (and rst): MAIN and SKID invalidated at the edge; input offered that cycle is not accepted; flush beats out_ready.
// - Reset values: out_valid=0, skid_valid=0, all out_* data fields 0; in_ready=0 during rst, 1 the cycle after.
// - Reset/flush mid-stall: held entries discarded, no transfer completes that cycle.
// STRUCTURE
// - Package rv_alu_pkg: ALU op code localparams (above), opcode constants (OP, OP_IMM, LUI, AUIPC, BRANCH),
//   funct7 constants, packed issue-entry struct width; shared with ALU and EX stage.
// - Sub-module alu_op_decode: purely combinational instr/pc/rs -> entry fields; this module adds the skid buffer.
// TESTING
// - rst 2 cycles -> out_valid=0, in_ready=0 in rst, 1 after; all outputs 0.
// - ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle op=0010, d1=5, d2=7, rd=3, reg_write=1.
// - SRAI x1,x2,4 (0x40415093) -> op=1101, d2=4; SUB (0x40208133) -> op=0110; LUI 0x12345 -> d1=0, d2=0x12345000.
// - Back-to-back 3 instrs, out_ready=0 cycles 1-3 -> in_ready=0 after 2nd accept; release -> issued in order, none lost.
// - BLTU (funct3 110) -> op=1011, branch=1, reg_write=0; opcode 0x0000000B or f7=0000001 -> illegal=1, op=0000.
// - MAIN+SKID full, assert flush with in_valid=1 -> next cycle out_valid=0, flushed/offered entries never appear.

Source files
------------

// File: rtl/rv_alu_pkg.sv
// Shared ALU issue definitions: op codes, RV32I opcode/funct7 constants and the issue-entry payload.
package rv_alu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SLT  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_SRL  = 4'b1100;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [3:0]      alu_op;
        logic [XLEN-1:0] data1;
        logic [XLEN-1:0] data2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            branch;
        logic [2:0]      funct3;
        logic            illegal;
    } issue_entry_t;

    localparam int unsigned ISSUE_ENTRY_W = $bits(issue_entry_t);

    // Integer funct3 -> ALU op; alt selects SUB/SRA on the 000/101 slots.
    function automatic logic [3:0] base_alu_op(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode of instruction, PC and register operands into an ALU issue entry.
module alu_op_decode
    import rv_alu_pkg::*;
(
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output issue_entry_t    o_entry
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_i_imm;
    logic [XLEN-1:0] w_u_imm;
    logic [XLEN-1:0] w_shamt;
    logic            w_is_shift;

    assign w_opcode   = i_instr[6:0];
    assign w_funct3   = i_instr[14:12];
    assign w_funct7   = i_instr[31:25];
    assign w_i_imm    = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_u_imm    = {i_instr[31:12], 12'b0};
    assign w_shamt    = {27'b0, i_instr[24:20]};
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    always_comb begin
        o_entry        = '0;
        o_entry.rd     = i_instr[11:7];
        o_entry.funct3 = w_funct3;
        case (w_opcode)
            OPC_OP: begin
                o_entry.alu_op    = base_alu_op(w_funct3, w_funct7 == F7_ALT);
                o_entry.data1     = i_rs1_data;
                o_entry.data2     = i_rs2_data;
                o_entry.reg_write = 1'b1;
                // Only ADD/SUB and SRL/SRA have a funct7 alternate; M-extension (0000001) falls here too.
                o_entry.illegal   = !((w_funct7 == F7_BASE) ||
                                      ((w_funct7 == F7_ALT) &&
                                       ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
            end
            OPC_OP_IMM: begin
                o_entry.alu_op    = base_alu_op(w_funct3, (w_funct3 == 3'b101) && (w_funct7 == F7_ALT));
                o_entry.data1     = i_rs1_data;
                o_entry.data2     = w_is_shift ? w_shamt : w_i_imm;
                o_entry.reg_write = 1'b1;
                o_entry.illegal   = ((w_funct3 == 3'b001) && (w_funct7 != F7_BASE)) ||
                                    ((w_funct3 == 3'b101) && (w_funct7 != F7_BASE) &&
                                     (w_funct7 != F7_ALT));
            end
            OPC_LUI: begin
                o_entry.alu_op    = ALU_ADD;
                o_entry.data2     = w_u_imm;
                o_entry.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                o_entry.alu_op    = ALU_ADD;
                o_entry.data1     = i_pc;
                o_entry.data2     = w_u_imm;
                o_entry.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                o_entry.data1  = i_rs1_data;
                o_entry.data2  = i_rs2_data;
                o_entry.branch = 1'b1;
                case (w_funct3[2:1])
                    2'b00:   o_entry.alu_op = ALU_SUB;
                    2'b10:   o_entry.alu_op = ALU_SLT;
                    2'b11:   o_entry.alu_op = ALU_SLTU;
                    default: o_entry.illegal = 1'b1;
                endcase
            end
            default: o_entry.illegal = 1'b1;
        endcase
        // Illegal encodings issue as an inert bubble carrying only rd/funct3.
        if (o_entry.illegal) begin
            o_entry.alu_op    = ALU_AND;
            o_entry.data1     = '0;
            o_entry.data2     = '0;
            o_entry.reg_write = 1'b0;
            o_entry.branch    = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes the instruction and registers it toward the ALU through a 2-entry skid buffer.
module alu_issue_stage
    import rv_alu_pkg::*;
#(
    parameter int unsigned XLEN_P = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN_P-1:0] in_instr,
    input  logic [XLEN_P-1:0] in_pc,
    input  logic [XLEN_P-1:0] in_rs1_data,
    input  logic [XLEN_P-1:0] in_rs2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_alu_operation,
    output logic [XLEN_P-1:0] out_data1,
    output logic [XLEN_P-1:0] out_data2,
    output logic [4:0]        out_rd,
    output logic              out_reg_write,
    output logic              out_branch,
    output logic [2:0]        out_funct3,
    output logic              out_illegal
);

    issue_entry_t w_dec;
    issue_entry_t r_main;
    issue_entry_t r_skid;
    logic         r_main_valid;
    logic         r_skid_valid;
    issue_entry_t w_main_nxt;
    issue_entry_t w_skid_nxt;
    logic         w_main_valid_nxt;
    logic         w_skid_valid_nxt;
    logic         w_accept;
    logic         w_consume;

    alu_op_decode u_decode (
        .i_instr    (in_instr),
        .i_pc       (in_pc),
        .i_rs1_data (in_rs1_data),
        .i_rs2_data (in_rs2_data),
        .o_entry    (w_dec)
    );

    assign in_ready  = !r_skid_valid && !rst && !flush;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_main_valid && out_ready;

    // MAIN refills from SKID first so ordering is preserved; a held MAIN diverts new entries to SKID.
    always_comb begin
        w_main_nxt       = r_main;
        w_main_valid_nxt = r_main_valid;
        w_skid_nxt       = r_skid;
        w_skid_valid_nxt = r_skid_valid;
        if (!r_main_valid || w_consume) begin
            if (r_skid_valid) begin
                w_main_nxt       = r_skid;
                w_main_valid_nxt = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end else if (w_accept) begin
                w_main_nxt       = w_dec;
                w_main_valid_nxt = 1'b1;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_nxt       = w_dec;
            w_skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            r_main       <= w_main_nxt;
            r_skid       <= w_skid_nxt;
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
        end
    end

    assign out_valid         = r_main_valid;
    assign out_alu_operation = r_main.alu_op;
    assign out_data1         = r_main.data1;
    assign out_data2         = r_main.data2;
    assign out_rd            = r_main.rd;
    assign out_reg_write     = r_main.reg_write;
    assign out_branch        = r_main.branch;
    assign out_funct3        = r_main.funct3;
    assign out_illegal       = r_main.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions queue expected entries, a monitor checks each issue.
module tb_alu_issue_stage;
    import rv_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_operation;
    logic [31:0] out_data1;
    logic [31:0] out_data2;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_branch;
    logic [2:0]  out_funct3;
    logic        out_illegal;

    issue_entry_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_issued = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_instr          (in_instr),
        .in_pc             (in_pc),
        .in_rs1_data       (in_rs1_data),
        .in_rs2_data       (in_rs2_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_alu_operation (out_alu_operation),
        .out_data1         (out_data1),
        .out_data2         (out_data2),
        .out_rd            (out_rd),
        .out_reg_write     (out_reg_write),
        .out_branch        (out_branch),
        .out_funct3        (out_funct3),
        .out_illegal       (out_illegal)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic issue_entry_t mk(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                                        input logic [4:0] rd, input logic rw, input logic br,
                                        input logic [2:0] f3, input logic ill);
        issue_entry_t e;
        e.alu_op = op; e.data1 = d1; e.data2 = d2; e.rd = rd;
        e.reg_write = rw; e.branch = br; e.funct3 = f3; e.illegal = ill;
        return e;
    endfunction

    function automatic issue_entry_t cur();
        return mk(out_alu_operation, out_data1, out_data2, out_rd, out_reg_write, out_branch,
                  out_funct3, out_illegal);
    endfunction

    // Monitor: every completed output transfer must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_issue: got %0h expected none", cur());
            end else begin
                issue_entry_t e;
                e = exp_q.pop_front();
                chk($sformatf("issue%0d", n_issued), 128'(cur()), 128'(e));
            end
            n_issued++;
        end
    end

    // Offer one instruction; called just after a rising edge, returns just after the accepting edge.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input issue_entry_t e);
        bit done = 0;
        int cyc  = 0;
        in_valid = 1'b1; in_instr = instr; in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                @(posedge clk); #1;
                done = 1;
            end else if (cyc > 50) begin
                n_checks++;
                $display("FAIL issue_timeout: instr %08h got no in_ready expected in_ready=1", instr);
                done = 1;
            end else begin
                cyc++;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;

        // Reset behaviour
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(in_ready), 128'd1);
        chk("post_rst_out_valid", 128'(out_valid), 128'd0);
        chk("post_rst_out_zero", 128'(cur()), 128'd0);
        @(posedge clk); #1;

        // Streaming decode vectors with out_ready held high
        out_ready = 1'b1;
        issue(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(ALU_ADD, 32'd5, 32'd7, 5'd3, 1, 0, 3'd0, 0));
        issue(32'h40415093, 32'h0, 32'h80000000, 32'd9,
              mk(ALU_SRA, 32'h80000000, 32'd4, 5'd1, 1, 0, 3'd5, 0));
        issue(32'h40208133, 32'h0, 32'd10, 32'd3, mk(ALU_SUB, 32'd10, 32'd3, 5'd2, 1, 0, 3'd0, 0));
        issue(32'h123452B7, 32'h40, 32'hDEAD, 32'hBEEF,
              mk(ALU_ADD, 32'd0, 32'h12345000, 5'd5, 1, 0, 3'd5, 0));
        issue(32'h00001317, 32'h100, 32'h55, 32'h66,
              mk(ALU_ADD, 32'h100, 32'h1000, 5'd6, 1, 0, 3'd1, 0));
        issue(32'hFFF00093, 32'h0, 32'h11, 32'h22,
              mk(ALU_ADD, 32'h11, 32'hFFFFFFFF, 5'd1, 1, 0, 3'd0, 0));
        issue(32'h0020E063, 32'h0, 32'd3, 32'd9, mk(ALU_SLTU, 32'd3, 32'd9, 5'd0, 0, 1, 3'd6, 0));
        issue(32'h00208063, 32'h0, 32'd4, 32'd4, mk(ALU_SUB, 32'd4, 32'd4, 5'd0, 0, 1, 3'd0, 0));
        issue(32'h0000000B, 32'h0, 32'd1, 32'd2, mk(ALU_AND, 32'd0, 32'd0, 5'd0, 0, 0, 3'd0, 1));
        issue(32'h022081B3, 32'h0, 32'd1, 32'd2, mk(ALU_AND, 32'd0, 32'd0, 5'd3, 0, 0, 3'd0, 1));
        issue(32'h0020A063, 32'h0, 32'd1, 32'd2, mk(ALU_AND, 32'd0, 32'd0, 5'd0, 0, 0, 3'd2, 1));
        issue(32'h0020A1B3, 32'h0, 32'hFFFFFFFF, 32'd1,
              mk(ALU_SLT, 32'hFFFFFFFF, 32'd1, 5'd3, 1, 0, 3'd2, 0));
        issue(32'h4020D1B3, 32'h0, 32'hF0, 32'd2, mk(ALU_SRA, 32'hF0, 32'd2, 5'd3, 1, 0, 3'd5, 0));
        issue(32'h00311093, 32'h0, 32'd6, 32'd8, mk(ALU_SLL, 32'd6, 32'd3, 5'd1, 1, 0, 3'd1, 0));
        issue(32'h00208033, 32'h0, 32'd1, 32'd1, mk(ALU_ADD, 32'd1, 32'd1, 5'd0, 1, 0, 3'd0, 0));
        idle(3);

        // Stall: two accepts fill MAIN and SKID, third waits until the ALU releases
        out_ready = 1'b0;
        issue(32'h0020F233, 32'h0, 32'hF0F0, 32'h0FF0, mk(ALU_AND, 32'hF0F0, 32'h0FF0, 5'd4, 1, 0, 3'd7, 0));
        issue(32'h0020E2B3, 32'h0, 32'h1, 32'h2, mk(ALU_OR, 32'h1, 32'h2, 5'd5, 1, 0, 3'd6, 0));
        @(negedge clk);
        chk("stall_in_ready", 128'(in_ready), 128'd0);
        chk("stall_out_valid", 128'(out_valid), 128'd1);
        chk("stall_main_first", 128'(cur()),
            128'(mk(ALU_AND, 32'hF0F0, 32'h0FF0, 5'd4, 1, 0, 3'd7, 0)));
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_main_hold", 128'(cur()),
            128'(mk(ALU_AND, 32'hF0F0, 32'h0FF0, 5'd4, 1, 0, 3'd7, 0)));
        @(posedge clk); #1;
        fork
            issue(32'hFF00C313, 32'h0, 32'h0F, 32'h0,
                  mk(ALU_XOR, 32'h0F, 32'hFFFFFFF0, 5'd6, 1, 0, 3'd4, 0));
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(4);
        chk("stall_drained", 128'(exp_q.size()), 128'd0);

        // Flush with MAIN+SKID full and a new instruction offered
        out_ready = 1'b0;
        issue(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(ALU_ADD, 32'd5, 32'd7, 5'd3, 1, 0, 3'd0, 0));
        issue(32'h40208133, 32'h0, 32'd10, 32'd3, mk(ALU_SUB, 32'd10, 32'd3, 5'd2, 1, 0, 3'd0, 0));
        exp_q.delete();
        flush = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h00311093; in_rs1_data = 32'd6;
        @(negedge clk);
        chk("flush_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 128'(out_valid), 128'd0);
        chk("flush_in_ready_after", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        issue(32'h0020B3B3, 32'h0, 32'd2, 32'd9, mk(ALU_SLTU, 32'd2, 32'd9, 5'd7, 1, 0, 3'd3, 0));
        idle(4);
        chk("final_drained", 128'(exp_q.size()), 128'd0);
        chk("final_out_valid", 128'(out_valid), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
